reg_write_buffer: RTL and testbench

REG_WRITE_BUFFER -- requirements
Module: reg_write_buffer

---
 rtl/reg_write_buffer_pkg.sv | 22 ++
 rtl/wb_match.sv | 44 ++++
 rtl/reg_write_buffer.sv | 160 ++++++++++++++++
 tb/tb_reg_write_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_buffer_pkg.sv
// Shared definitions for the register-file write buffer.
//
// Contents:
//   WB_DEPTH   - default number of pending write entries
//   WB_ADDR_W  - default register index width (16 registers)
//   WB_DATA_W  - default register data width
//   wb_entry_t - one pending write: {valid, addr, data}
//
// Configuration macro: WB_COALESCE_EN (consumed by reg_write_buffer).
package reg_write_buffer_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-match search over the write buffer entries for one read port.
//
// Ports:
//   valid_i   - per-slot valid bits
//   addr_i    - per-slot destination register index
//   data_i    - per-slot pending data
//   head_i    - slot index of the oldest entry (read pointer)
//   rd_addr_i - register index being read
//   hit_o     - some valid entry targets rd_addr_i
//   data_o    - data of the youngest matching entry, 0 when no hit
module wb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int PTR_W  = 2
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [PTR_W-1:0]             head_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  logic [PTR_W-1:0] idx;

  // Walk slots from oldest to youngest so that a later (younger) match
  // overrides an earlier one; the pointer sum wraps because DEPTH is a
  // power of two.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] && (addr_i[idx] == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/reg_write_buffer.sv
// In-order write buffer sitting in front of a register file write port.
// Writes are queued, drained one per cycle when the port is free, and any
// pending value is forwarded to the two read ports.
//
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   wr_valid/addr/data     - producer write request
//   wr_ready               - buffer accepts the write this cycle
//   rf_stall               - register file write port busy
//   rf_ld/rf_addr/rf_data  - head entry presented to the register file
//   rd_addr_a/b            - read-port indices
//   hit_a/b, fwd_data_a/b  - pending-write forwarding results
//   count                  - current occupancy
//
// Configuration macro: WB_COALESCE_EN - a write to the same register as
// the youngest pending entry overwrites it instead of allocating.
module reg_write_buffer
  import reg_write_buffer_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   rf_stall,
  output logic                   rf_ld,
  output logic [ADDR_W-1:0]      rf_addr,
  output logic [DATA_W-1:0]      rf_data,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic                   hit_a,
  output logic                   hit_b,
  output logic [DATA_W-1:0]      fwd_data_a,
  output logic [DATA_W-1:0]      fwd_data_b,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  logic notEmpty;
  logic isFull;
  logic popHead;
  logic pushAlloc;

  assign notEmpty = (count_q != '0);
  assign isFull   = (count_q == CNT_W'(DEPTH));
  assign popHead  = notEmpty && !rf_stall;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] youngPtr;
  logic             coalesceHit;

  // The youngest entry sits just behind the write pointer. Merging is
  // refused when that entry is also the head leaving this cycle, since the
  // new data would otherwise be lost with it.
  assign youngPtr    = wr_ptr_q - PTR_W'(1);
  assign coalesceHit = wr_valid && notEmpty && (addr_q[youngPtr] == wr_addr) &&
                       !(popHead && (count_q == CNT_W'(1)));
  assign wr_ready    = !isFull || coalesceHit;
  assign pushAlloc   = wr_valid && wr_ready && !coalesceHit;
`else
  assign wr_ready  = !isFull;
  assign pushAlloc = wr_valid && !isFull;
`endif

  assign rf_ld   = popHead;
  assign rf_addr = notEmpty ? addr_q[rd_ptr_q] : '0;
  assign rf_data = notEmpty ? data_q[rd_ptr_q] : '0;
  assign count   = count_q;

  // Next-state for the entry storage and pointers. Pop and allocate never
  // touch the same slot: pop needs a non-empty buffer and allocate a
  // non-full one, so their slots differ whenever both happen.
  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (popHead) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
`ifdef WB_COALESCE_EN
    if (coalesceHit) begin
      data_d[youngPtr] = wr_data;
    end
`endif
    if (pushAlloc) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = wr_addr;
      data_d[wr_ptr_q]  = wr_data;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(pushAlloc) - CNT_W'(popHead);
  end

  // State registers; reset discards all pending entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) matchA (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .head_i    (rd_ptr_q),
    .rd_addr_i (rd_addr_a),
    .hit_o     (hit_a),
    .data_o    (fwd_data_a)
  );

  wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) matchB (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .head_i    (rd_ptr_q),
    .rd_addr_i (rd_addr_b),
    .hit_o     (hit_b),
    .data_o    (fwd_data_b)
  );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench for reg_write_buffer: a table of hand-computed
// vectors, a few multi-cycle sequences, and randomized traffic checked
// against a queue-based reference model.
module tb_reg_write_buffer;
  import reg_write_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = WB_ADDR_W;
  localparam int DATA_W = WB_DATA_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef WB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rf_stall = 1'b0;
  logic              rf_ld;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b;
  logic [CNT_W-1:0]  count;

  typedef struct {
    logic              ready;
    logic              ld;
    logic [ADDR_W-1:0] rfAddr;
    logic [DATA_W-1:0] rfData;
    logic              hitA;
    logic [DATA_W-1:0] fwdA;
    logic              hitB;
    logic [DATA_W-1:0] fwdB;
    logic [CNT_W-1:0]  cnt;
  } outs_t;

  typedef struct {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              stall;
    logic [ADDR_W-1:0] rdA;
    logic [ADDR_W-1:0] rdB;
    outs_t             want;
  } vec_t;

  vec_t      tbl[22];
  wb_entry_t model[$];
  int        vectors = 0;
  int        miscompares = 0;

  reg_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rf_stall   (rf_stall),
    .rf_ld      (rf_ld),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .count      (count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic setVec(input int i, input logic v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic s,
                        input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                        input logic rdy, input logic ld, input logic [ADDR_W-1:0] rfa,
                        input logic [DATA_W-1:0] rfd, input logic ha,
                        input logic [DATA_W-1:0] fa, input logic hb,
                        input logic [DATA_W-1:0] fb, input logic [CNT_W-1:0] cnt);
    tbl[i].valid       = v;
    tbl[i].addr        = a;
    tbl[i].data        = d;
    tbl[i].stall       = s;
    tbl[i].rdA         = ra;
    tbl[i].rdB         = rb;
    tbl[i].want.ready  = rdy;
    tbl[i].want.ld     = ld;
    tbl[i].want.rfAddr = rfa;
    tbl[i].want.rfData = rfd;
    tbl[i].want.hitA   = ha;
    tbl[i].want.fwdA   = fa;
    tbl[i].want.hitB   = hb;
    tbl[i].want.fwdB   = fb;
    tbl[i].want.cnt    = cnt;
  endtask

  // Drive one cycle's inputs on the falling edge, settle, then return.
  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic s,
                               input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
    @(negedge clk);
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    rf_stall  = s;
    rd_addr_a = ra;
    rd_addr_b = rb;
    #1;
  endtask

  // Compare every output against the expected record.
  task automatic checkOutput(input string tag, input outs_t e, input bit chkReady);
    bit bad;
    bad = 1'b0;
    vectors++;
    if (chkReady && (wr_ready !== e.ready)) begin
      $display("[TB] FAIL %s wr_ready got %0b want %0b", tag, wr_ready, e.ready); bad = 1'b1;
    end
    if (rf_ld !== e.ld) begin
      $display("[TB] FAIL %s rf_ld got %0b want %0b", tag, rf_ld, e.ld); bad = 1'b1;
    end
    if (rf_addr !== e.rfAddr) begin
      $display("[TB] FAIL %s rf_addr got %0d want %0d", tag, rf_addr, e.rfAddr); bad = 1'b1;
    end
    if (rf_data !== e.rfData) begin
      $display("[TB] FAIL %s rf_data got %h want %h", tag, rf_data, e.rfData); bad = 1'b1;
    end
    if (hit_a !== e.hitA) begin
      $display("[TB] FAIL %s hit_a got %0b want %0b", tag, hit_a, e.hitA); bad = 1'b1;
    end
    if (fwd_data_a !== e.fwdA) begin
      $display("[TB] FAIL %s fwd_data_a got %h want %h", tag, fwd_data_a, e.fwdA); bad = 1'b1;
    end
    if (hit_b !== e.hitB) begin
      $display("[TB] FAIL %s hit_b got %0b want %0b", tag, hit_b, e.hitB); bad = 1'b1;
    end
    if (fwd_data_b !== e.fwdB) begin
      $display("[TB] FAIL %s fwd_data_b got %h want %h", tag, fwd_data_b, e.fwdB); bad = 1'b1;
    end
    if (count !== e.cnt) begin
      $display("[TB] FAIL %s count got %0d want %0d", tag, count, e.cnt); bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  // Reference: would the current request merge into the youngest entry?
  function automatic bit modelCoalesce(input bit ld);
    int n;
    n = model.size();
    if (!COALESCE || !wr_valid || n == 0) return 1'b0;
    if (model[n-1].addr != wr_addr) return 1'b0;
    return !(ld && n == 1);
  endfunction

  // Reference outputs from the pending-write queue (index 0 = oldest).
  function automatic outs_t modelExpect();
    outs_t e;
    int    n;
    n        = model.size();
    e.cnt    = CNT_W'(n);
    e.ld     = (n != 0) && !rf_stall;
    e.rfAddr = (n != 0) ? model[0].addr : '0;
    e.rfData = (n != 0) ? model[0].data : '0;
    e.ready  = (n < DEPTH) || modelCoalesce(e.ld);
    e.hitA = 1'b0; e.fwdA = '0; e.hitB = 1'b0; e.fwdB = '0;
    for (int i = 0; i < n; i++) begin
      if (model[i].addr == rd_addr_a) begin e.hitA = 1'b1; e.fwdA = model[i].data; end
      if (model[i].addr == rd_addr_b) begin e.hitB = 1'b1; e.fwdB = model[i].data; end
    end
    return e;
  endfunction

  // One model-checked cycle: drive, compare, then advance the model.
  task automatic modelStep(input string tag, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic s,
                           input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
    outs_t     e;
    bit        coal;
    wb_entry_t ent;
    applyStimulus(v, a, d, s, ra, rb);
    e = modelExpect();
    checkOutput(tag, e, 1'b1);
    coal = modelCoalesce(e.ld);
    if (coal) begin
      ent = model[model.size()-1];
      ent.data = wr_data;
      model[model.size()-1] = ent;
    end
    if (e.ld) void'(model.pop_front());
    if (wr_valid && e.ready && !coal) begin
      ent.valid = 1'b1;
      ent.addr  = wr_addr;
      ent.data  = wr_data;
      model.push_back(ent);
    end
    @(posedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b0; rf_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model.delete();
  endtask

  initial begin
    outs_t zero;
    zero = '{ready:1'b1, ld:1'b0, rfAddr:'0, rfData:'0, hitA:1'b0, fwdA:'0,
             hitB:1'b0, fwdB:'0, cnt:'0};

    // Single write drains one cycle after acceptance; full buffer holds
    // four stalled writes; youngest duplicate wins forwarding.
    setVec( 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
    setVec( 1, 1, 3, 32'hFFFFFF00, 0, 3, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
    setVec( 2, 0, 0, 32'h0,        0, 3, 0, 1, 1, 3, 32'hFFFFFF00, 1, 32'hFFFFFF00, 0, 32'h0,   1);
    setVec( 3, 0, 0, 32'h0,        0, 3, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
    setVec( 4, 1, 0, 32'h100,      1, 0, 1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
    setVec( 5, 1, 1, 32'h101,      1, 0, 1, 1, 0, 0, 32'h100,      1, 32'h100,      0, 32'h0,   1);
    setVec( 6, 1, 2, 32'h102,      1, 0, 1, 1, 0, 0, 32'h100,      1, 32'h100,      1, 32'h101, 2);
    setVec( 7, 1, 3, 32'h103,      1, 0, 1, 1, 0, 0, 32'h100,      1, 32'h100,      1, 32'h101, 3);
    setVec( 8, 1, 9, 32'h999,      1, 0, 3, 0, 0, 0, 32'h100,      1, 32'h100,      1, 32'h103, 4);
    setVec( 9, 0, 0, 32'h0,        0, 0, 3, 0, 1, 0, 32'h100,      1, 32'h100,      1, 32'h103, 4);
    setVec(10, 0, 0, 32'h0,        0, 0, 3, 1, 1, 1, 32'h101,      0, 32'h0,        1, 32'h103, 3);
    setVec(11, 0, 0, 32'h0,        0, 0, 3, 1, 1, 2, 32'h102,      0, 32'h0,        1, 32'h103, 2);
    setVec(12, 0, 0, 32'h0,        0, 0, 3, 1, 1, 3, 32'h103,      0, 32'h0,        1, 32'h103, 1);
    setVec(13, 0, 0, 32'h0,        0, 0, 3, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
    setVec(14, 1, 5, 32'h11,       1, 5, 6, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
    setVec(15, 1, 7, 32'h77,       1, 5, 6, 1, 0, 5, 32'h11,       1, 32'h11,       0, 32'h0,   1);
    setVec(16, 1, 5, 32'h22,       1, 5, 6, 1, 0, 5, 32'h11,       1, 32'h11,       0, 32'h0,   2);
    setVec(17, 0, 0, 32'h0,        1, 5, 6, 1, 0, 5, 32'h11,       1, 32'h22,       0, 32'h0,   3);
    setVec(18, 0, 0, 32'h0,        0, 5, 6, 1, 1, 5, 32'h11,       1, 32'h22,       0, 32'h0,   3);
    setVec(19, 0, 0, 32'h0,        0, 5, 6, 1, 1, 7, 32'h77,       1, 32'h22,       0, 32'h0,   2);
    setVec(20, 0, 0, 32'h0,        0, 5, 6, 1, 1, 5, 32'h22,       1, 32'h22,       0, 32'h0,   1);
    setVec(21, 0, 0, 32'h0,        0, 5, 6, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);

    // Outputs while held in reset.
    @(negedge clk);
    #1;
    checkOutput("in_reset", zero, 1'b0);
    doReset();

    $display("[TB] table vectors");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].stall, tbl[i].rdA, tbl[i].rdB);
      checkOutput($sformatf("vec%0d", i), tbl[i].want, 1'b1);
      @(posedge clk);
    end

    $display("[TB] simultaneous push/pop with pointer wrap");
    doReset();
    modelStep("pp_fill", 1, 1, 32'hA1, 1, 1, 2);
    modelStep("pp_fill", 1, 2, 32'hA2, 1, 1, 2);
    for (int i = 0; i < 6; i++) begin
      modelStep("pp_both", 1, ADDR_W'(8 + i), DATA_W'(32'hB0 + i), 0, ADDR_W'(8 + i), 2);
    end
    for (int i = 0; i < 3; i++) modelStep("pp_drain", 0, 0, 0, 0, 12, 13);

    $display("[TB] write to full buffer matching youngest entry");
    modelStep("co_fill", 1, 1, 32'h01, 1, 7, 1);
    modelStep("co_fill", 1, 2, 32'h02, 1, 7, 1);
    modelStep("co_fill", 1, 3, 32'h03, 1, 7, 1);
    modelStep("co_fill", 1, 7, 32'h07, 1, 7, 1);
    modelStep("co_full", 1, 7, 32'hAB, 1, 7, 1);
    for (int i = 0; i < 5; i++) modelStep("co_drain", 0, 0, 0, 0, 7, 3);

    $display("[TB] reset with entries pending");
    modelStep("rs_fill", 1, 4, 32'h44, 1, 4, 5);
    modelStep("rs_fill", 1, 5, 32'h55, 1, 4, 5);
    modelStep("rs_fill", 1, 6, 32'h66, 1, 4, 5);
    applyStimulus(0, 0, 0, 0, 4, 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rs_async", zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    modelStep("rs_after", 0, 0, 0, 0, 4, 5);
    modelStep("rs_after", 0, 0, 0, 0, 4, 5);
    modelStep("rs_push", 1, 0, 32'hC0, 0, 0, 5);
    modelStep("rs_reg0", 0, 0, 0, 0, 0, 5);
    modelStep("rs_idle", 0, 0, 0, 0, 0, 5);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic              v, s;
      logic [ADDR_W-1:0] a, ra, rb;
      logic [DATA_W-1:0] d;
      v  = ($urandom_range(0, 99) < 60);
      s  = ($urandom_range(0, 99) < 40);
      a  = ADDR_W'($urandom_range(0, 7));
      ra = ADDR_W'($urandom_range(0, 7));
      rb = ADDR_W'($urandom_range(0, 7));
      d  = DATA_W'($urandom);
      modelStep("rand", v, a, d, s, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
